md5_engine_pool: RTL and testbench

// - Parametrised pool of NUM_UNITS md5_engine instances behind one block stream and one result stream.
// - Dispatch skips busy units: each block goes to the next free unit in round-robin order.
// - Every block carries a sequence number, captured at dispatch and returned with any result it produces.
// - Results are held per unit and drained round-robin under ready/valid backpressure, so simultaneous matches are never lost.
// - Sits between the block generator and the answer/min-index tracker.

---
 rtl/md5_pool_pkg.sv | 23 ++
 rtl/md5_engine.sv | 42 ++++
 rtl/rr_arbiter.sv | 27 ++
 rtl/md5_engine_pool.sv | 116 +++++++++++
 tb/tb_md5_engine_pool.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/md5_pool_pkg.sv
// Shared types and helpers for the md5 engine pool.
package md5_pool_pkg;

    localparam int BLOCK_WIDTH  = 512;
    localparam int RESULT_WIDTH = 32;
    localparam int SEQ_WIDTH    = 32;
    localparam int MAX_UNITS    = 32;

    typedef logic [SEQ_WIDTH-1:0]           seq_t;
    typedef logic [RESULT_WIDTH-1:0]        result_t;
    typedef logic [$clog2(MAX_UNITS)-1:0]   unit_idx_t;

    typedef struct packed {
        result_t data;
        seq_t    seq;
    } result_entry_t;

    // Cyclic successor of ptr in 0..n-1.
    function automatic unit_idx_t next_index(unit_idx_t ptr, int n);
        return (int'(ptr) >= n - 1) ? '0 : unit_idx_t'(ptr + 1'b1);
    endfunction

endpackage

// File: rtl/md5_engine.sv
// Cycle-level md5 engine: accepts one block when idle, stays busy for the
// latency carried in the block, then pulses its result if the block matched.
// Block fields: [7:0] latency (0 treated as 1), [8] match, [9] pulse twice
// on back-to-back cycles, [63:32] result value.
module md5_engine
    import md5_pool_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic [BLOCK_WIDTH-1:0] block_i,
    output logic                   ready_o,
    output logic                   result_valid_o,
    output result_t                result_o
);

    logic [7:0] cnt_q;
    logic       match_q, dbl_q;
    result_t    res_q;

    // Capture a block on handshake, then count down to completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            match_q <= 1'b0;
            dbl_q   <= 1'b0;
            res_q   <= '0;
        end else if (valid_i && ready_o) begin
            cnt_q   <= (block_i[7:0] == 8'd0) ? 8'd1 : block_i[7:0];
            match_q <= block_i[8];
            dbl_q   <= block_i[9];
            res_q   <= block_i[63:32];
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign ready_o        = (cnt_q == 8'd0);
    assign result_valid_o = match_q && ((cnt_q == 8'd1) || (dbl_q && cnt_q == 8'd2));
    assign result_o       = res_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i, searching cyclically.
module rr_arbiter #(
    parameter int  N  = 7,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                idx_o = IW'((int'(ptr_i) + k) % N);
                any_o = 1'b1;
            end
        end
        gnt_o        = '0;
        gnt_o[idx_o] = any_o;
    end

endmodule

// File: rtl/md5_engine_pool.sv
// Pool of md5 engines: round-robin dispatch to free units, per-unit result
// slots, round-robin registered drain with ready/valid backpressure.
module md5_engine_pool
    import md5_pool_pkg::*;
#(
    parameter int  NUM_UNITS = 7,
    localparam int UW        = $clog2(NUM_UNITS)
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    output logic                   md5_block_ready_o,
    input  logic                   md5_block_valid_i,
    input  logic [BLOCK_WIDTH-1:0] md5_block_data_i,
    input  logic                   result_ready_i,
    output logic                   result_valid_o,
    output result_t                result_data_o,
    output seq_t                   result_seq_o,
    output logic [UW-1:0]          result_unit_o,
    output logic                   overflow_o
);

    logic [1:0]           rst_sync_q;
    logic                 rst_n;
    logic [NUM_UNITS-1:0] eng_ready, eng_rv, slot_full, elig, disp_gnt, drn_gnt;
    result_t              eng_res   [NUM_UNITS];
    result_entry_t        slot_data [NUM_UNITS];
    logic [UW-1:0]        disp_idx, drn_idx, disp_ptr_q, res_ptr_q;
    logic                 disp_any, drn_any, fire, load;
    seq_t                 seq_cnt_q;

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign elig              = eng_ready & ~slot_full;
    assign md5_block_ready_o = disp_any;
    assign fire              = md5_block_valid_i & disp_any;
    assign load              = !result_valid_o || result_ready_i;

    rr_arbiter #(.N(NUM_UNITS)) u_disp_arb (
        .req_i(elig), .ptr_i(disp_ptr_q), .gnt_o(disp_gnt), .idx_o(disp_idx), .any_o(disp_any)
    );

    rr_arbiter #(.N(NUM_UNITS)) u_drain_arb (
        .req_i(slot_full), .ptr_i(res_ptr_q), .gnt_o(drn_gnt), .idx_o(drn_idx), .any_o(drn_any)
    );

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        logic          full_q;
        result_entry_t slot_q;
        seq_t          tag_q;

        md5_engine u_eng (
            .clk_i          (clk_i),
            .rst_ni         (rst_n),
            .valid_i        (fire & disp_gnt[i]),
            .block_i        (md5_block_data_i),
            .ready_o        (eng_ready[i]),
            .result_valid_o (eng_rv[i]),
            .result_o       (eng_res[i])
        );

        // Tag on dispatch; capture a pulse into an empty slot, free on drain.
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                full_q <= 1'b0;
                slot_q <= '0;
                tag_q  <= '0;
            end else begin
                if (fire && disp_gnt[i]) tag_q <= seq_cnt_q;
                if (eng_rv[i] && !full_q) begin
                    full_q <= 1'b1;
                    slot_q <= '{data: eng_res[i], seq: tag_q};
                end else if (load && drn_gnt[i]) begin
                    full_q <= 1'b0;
                end
            end
        end

        assign slot_full[i] = full_q;
        assign slot_data[i] = slot_q;
    end

    // Sequence/pointer bookkeeping, sticky overflow and the output register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt_q      <= '0;
            disp_ptr_q     <= '0;
            res_ptr_q      <= '0;
            overflow_o     <= 1'b0;
            result_valid_o <= 1'b0;
            result_data_o  <= '0;
            result_seq_o   <= '0;
            result_unit_o  <= '0;
        end else begin
            if (|(eng_rv & slot_full)) overflow_o <= 1'b1;
            if (fire) begin
                seq_cnt_q  <= seq_cnt_q + 1'b1;
                disp_ptr_q <= UW'(next_index(unit_idx_t'(disp_idx), NUM_UNITS));
            end
            if (load) begin
                result_valid_o <= drn_any;
                if (drn_any) begin
                    result_data_o <= slot_data[drn_idx].data;
                    result_seq_o  <= slot_data[drn_idx].seq;
                    result_unit_o <= drn_idx;
                    res_ptr_q     <= UW'(next_index(unit_idx_t'(drn_idx), NUM_UNITS));
                end
            end
        end
    end

endmodule

// File: tb/tb_md5_engine_pool.sv
// Directed bench for md5_engine_pool (7 units).
module tb_md5_engine_pool;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_ready;
    logic         res_ready;
    logic         res_valid;
    logic [31:0]  res_data;
    logic [31:0]  res_seq;
    logic [2:0]   res_unit;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] seq;
        int          unit;
    } exp_t;

    exp_t        tbl[$];
    logic [31:0] q_data[$];
    logic [31:0] q_seq[$];
    int          q_unit[$];
    int          q_cyc[$];

    md5_engine_pool #(.NUM_UNITS(7)) dut (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .md5_block_ready_o (blk_ready),
        .md5_block_valid_i (blk_valid),
        .md5_block_data_i  (blk_data),
        .result_ready_i    (res_ready),
        .result_valid_o    (res_valid),
        .result_data_o     (res_data),
        .result_seq_o      (res_seq),
        .result_unit_o     (res_unit),
        .overflow_o        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every negedge with valid&ready is one transfer at the next posedge.
    always @(negedge clk) begin
        if (reset_n && res_valid && res_ready) begin
            q_data.push_back(res_data);
            q_seq.push_back(res_seq);
            q_unit.push_back(int'(res_unit));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk(input int lat, input bit m, input bit d, input logic [31:0] tag);
        logic [511:0] b;
        b        = '0;
        b[7:0]   = 8'(lat);
        b[8]     = m;
        b[9]     = d;
        b[63:32] = tag;
        return b;
    endfunction

    task automatic q_clear();
        q_data.delete(); q_seq.delete(); q_unit.delete(); q_cyc.delete();
    endtask

    task automatic send(input logic [511:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        blk_valid = 1'b1;
        blk_data  = b;
        while (!blk_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        acc       = cyc;
        blk_valid = 1'b0;
    endtask

    task automatic wait_n(input string nm, input int n);
        int k;
        k = 0;
        while (q_seq.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, q_seq.size(), n);
    endtask

    task automatic cmp_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i < q_seq.size()) begin
                chk($sformatf("%s_data%0d", nm, i), q_data[i], tbl[i].data);
                chk($sformatf("%s_seq%0d", nm, i), q_seq[i], tbl[i].seq);
                chk($sformatf("%s_unit%0d", nm, i), q_unit[i], tbl[i].unit);
            end else begin
                chk($sformatf("%s_missing%0d", nm, i), q_seq.size(), tbl.size());
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int pat[5];
        int chg, rdy_hi;
        logic [31:0] snap_d, snap_s;
        int snap_u;
        pat = '{0, 1, 3, 4, 6};
        reset_n = 1'b0; blk_valid = 1'b0; blk_data = '0; res_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", res_data, 0);
        chk("rst_seq", res_seq, 0);
        chk("rst_unit", res_unit, 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_blk_ready", blk_ready, 1);

        // Single block, match: seq 0, unit 0, two cycles to result_valid
        q_clear();
        send(mk(1, 1, 0, 32'h0000_1234), acc);
        wait_n("t1_count", 1);
        if (q_seq.size() >= 1) begin
            chk("t1_latency", q_cyc[0] - acc, 2);
            chk("t1_data", q_data[0], 32'h0000_1234);
            chk("t1_seq", q_seq[0], 0);
            chk("t1_unit", q_unit[0], 0);
        end
        chk("t1_ovf", ovf, 0);

        // Units 2 and 5 held busy; 20 blocks skip them, tags consecutive
        do_reset();
        q_clear();
        for (int k = 0; k < 7; k++) send(mk((k == 2 || k == 5) ? 255 : 1, 0, 0, 32'h0), acc);
        tbl.delete();
        for (int j = 0; j < 20; j++) tbl.push_back('{32'hA000 + j, 32'(7 + j), pat[j % 5]});
        for (int j = 0; j < 20; j++) send(mk(3, 1, 0, tbl[j].data), acc);
        wait_n("t2_count", 20);
        cmp_tbl("t2");

        // Units 1, 3, 6 pulse together: drained 1, 3, 6 on consecutive cycles
        do_reset();
        q_clear();
        for (int k = 0; k < 7; k++) begin
            if (k == 1 || k == 3 || k == 6) send(mk(10 - k, 1, 0, 32'hB000 + k), acc);
            else                            send(mk(1, 0, 0, 32'h0), acc);
        end
        tbl.delete();
        tbl.push_back('{32'hB001, 32'd1, 1});
        tbl.push_back('{32'hB003, 32'd3, 3});
        tbl.push_back('{32'hB006, 32'd6, 6});
        wait_n("t3_count", 3);
        cmp_tbl("t3");
        if (q_cyc.size() >= 3) begin
            chk("t3_back2back_a", q_cyc[1] - q_cyc[0], 1);
            chk("t3_back2back_b", q_cyc[2] - q_cyc[1], 1);
        end

        // Backpressure: output plus all slots full, frozen for 50 cycles
        do_reset();
        q_clear();
        res_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(mk(2, 1, 0, 32'hC000 + k), acc);
        repeat (10) @(negedge clk);
        snap_d = res_data; snap_s = res_seq; snap_u = int'(res_unit);
        chk("t4_hold_valid", res_valid, 1);
        chk("t4_hold_data", snap_d, 32'hC000);
        chk("t4_hold_seq", snap_s, 0);
        chk("t4_hold_unit", snap_u, 0);
        chg = 0; rdy_hi = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!res_valid || res_data != snap_d || res_seq != snap_s || int'(res_unit) != snap_u) chg++;
            if (blk_ready) rdy_hi++;
        end
        chk("t4_frozen", chg, 0);
        chk("t4_blk_ready_low", rdy_hi, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        tbl.delete();
        for (int k = 0; k < 8; k++) tbl.push_back('{32'hC000 + k, 32'(k), k % 7});
        wait_n("t4_count", 8);
        cmp_tbl("t4");

        // Double pulse on full slot 4: overflow sticky, original entry kept
        do_reset();
        q_clear();
        res_ready = 1'b0;
        send(mk(2, 1, 0, 32'hD000), acc);
        for (int k = 1; k < 4; k++) send(mk(1, 0, 0, 32'h0), acc);
        send(mk(3, 1, 1, 32'hD004), acc);
        repeat (20) @(negedge clk);
        chk("t5_ovf_set", ovf, 1);
        repeat (20) @(negedge clk);
        chk("t5_ovf_sticky", ovf, 1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        tbl.delete();
        tbl.push_back('{32'hD000, 32'd0, 0});
        tbl.push_back('{32'hD004, 32'd4, 4});
        wait_n("t5_count", 2);
        repeat (10) @(negedge clk);
        chk("t5_no_extra", q_seq.size(), 2);
        cmp_tbl("t5");
        chk("t5_ovf_after", ovf, 1);

        // Reset mid-operation with result_valid high and a block in flight
        res_ready = 1'b0;
        send(mk(2, 1, 0, 32'hE555), acc);
        send(mk(60, 1, 0, 32'hE666), acc);
        repeat (10) @(negedge clk);
        chk("t6_pre_valid", res_valid, 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", res_valid, 0);
        chk("t6_rst_ovf", ovf, 0);
        chk("t6_rst_data", res_data, 0);
        chk("t6_rst_seq", res_seq, 0);
        chk("t6_rst_unit", res_unit, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        res_ready = 1'b1;
        repeat (4) @(posedge clk);
        q_clear();
        repeat (80) @(negedge clk);
        chk("t6_inflight_dropped", q_seq.size(), 0);
        send(mk(2, 1, 0, 32'hE000), acc);
        tbl.delete();
        tbl.push_back('{32'hE000, 32'd0, 0});
        wait_n("t6_count", 1);
        cmp_tbl("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
